// File: rtl/mult16_cpa_pipe.sv
// Two-stage carry-propagate adder that resolves the compressor's 32-bit carry-save pair
// into the product, with valid/ready flow control and a saturating bit-32 carry-out counter.
module mult16_cpa_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_sum,
    input  logic [31:0]      in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prod,
    output logic             out_c32,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_lo_q, s1_lo_d;
    logic             s1_c16_q, s1_c16_d;
    logic [15:0]      s1_sum_hi_q, s1_sum_hi_d;
    logic [15:0]      s1_carry_hi_q, s1_carry_hi_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_prod_q, s2_prod_d;
    logic             s2_c32_q, s2_c32_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic        adv1, adv2, out_xfer;
    logic [16:0] lo_sum, hi_sum;

    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1 && !rst;
        out_xfer = s2_valid_q && out_ready;

        lo_sum = {1'b0, in_sum[15:0]} + {1'b0, in_carry[15:0]};
        hi_sum = {1'b0, s1_sum_hi_q} + {1'b0, s1_carry_hi_q} + {16'd0, s1_c16_q};

        // NOTE: every next-state value gets a hold default first so no latch is inferred.
        s1_valid_d    = s1_valid_q;
        s1_lo_d       = s1_lo_q;
        s1_c16_d      = s1_c16_q;
        s1_sum_hi_d   = s1_sum_hi_q;
        s1_carry_hi_d = s1_carry_hi_q;
        s2_valid_d    = s2_valid_q;
        s2_prod_d     = s2_prod_q;
        s2_c32_d      = s2_c32_q;
        ovf_cnt_d     = ovf_cnt_q;

        if (adv1) begin
            s1_valid_d    = in_valid && in_ready;
            s1_lo_d       = lo_sum[15:0];
            s1_c16_d      = lo_sum[16];
            s1_sum_hi_d   = in_sum[31:16];
            s1_carry_hi_d = in_carry[31:16];
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            s2_prod_d  = {hi_sum[15:0], s1_lo_q};
            s2_c32_d   = hi_sum[16];
        end

        // Counted on the output handshake so a stalled beat is seen exactly once.
        if (out_xfer && s2_c32_q && (ovf_cnt_q != CNT_MAX))
            ovf_cnt_d = ovf_cnt_q + CNT_ONE;
    end

    // NOTE: state registers use non-blocking assignments so all stages update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_lo_q       <= '0;
            s1_c16_q      <= 1'b0;
            s1_sum_hi_q   <= '0;
            s1_carry_hi_q <= '0;
            s2_valid_q    <= 1'b0;
            s2_prod_q     <= '0;
            s2_c32_q      <= 1'b0;
            ovf_cnt_q     <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_lo_q       <= s1_lo_d;
            s1_c16_q      <= s1_c16_d;
            s1_sum_hi_q   <= s1_sum_hi_d;
            s1_carry_hi_q <= s1_carry_hi_d;
            s2_valid_q    <= s2_valid_d;
            s2_prod_q     <= s2_prod_d;
            s2_c32_q      <= s2_c32_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_prod  = s2_prod_q;
    assign out_c32   = s2_c32_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_mult16_cpa_pipe.sv
// Self-checking bench for mult16_cpa_pipe: a default-width instance and a CNT_W=2 instance
// share stimulus; a scoreboard queue tracks expected products in FIFO order.
module tb_mult16_cpa_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready;
    logic [31:0] in_sum, in_carry;
    logic        in_ready, out_valid, out_c32;
    logic [31:0] out_prod;
    logic [15:0] ovf_cnt;
    logic        sat_in_ready, sat_out_valid, sat_out_c32;
    logic [31:0] sat_out_prod;
    logic [1:0]  sat_ovf_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt_sat;

    mult16_cpa_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_c32(out_c32), .ovf_cnt(ovf_cnt)
    );

    mult16_cpa_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_prod(sat_out_prod), .out_c32(sat_out_c32),
        .ovf_cnt(sat_ovf_cnt)
    );

    // Scoreboard monitor: samples on the falling edge, between driven input changes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt     = '0;
            exp_cnt_sat = '0;
        end else begin
            checks++;
            if (ovf_cnt !== exp_cnt || sat_ovf_cnt !== exp_cnt_sat) begin
                errors++;
                $display("FAIL ovf_cnt: got %0d/%0d expected %0d/%0d",
                         ovf_cnt, sat_ovf_cnt, exp_cnt, exp_cnt_sat);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_prod);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({out_c32, out_prod} !== mon_exp) begin
                        errors++;
                        $display("FAIL product: got c32=%b prod=%h expected c32=%b prod=%h",
                                 out_c32, out_prod, mon_exp[32], mon_exp[31:0]);
                    end
                    checks++;
                    if ({sat_out_valid, sat_out_c32, sat_out_prod} !== {1'b1, mon_exp}) begin
                        errors++;
                        $display("FAIL sat_product: got v=%b c32=%b prod=%h expected v=1 c32=%b prod=%h",
                                 sat_out_valid, sat_out_c32, sat_out_prod, mon_exp[32], mon_exp[31:0]);
                    end
                    if (mon_exp[32]) begin
                        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                        if (exp_cnt_sat != 2'd3) exp_cnt_sat = exp_cnt_sat + 2'd1;
                    end
                end
            end
            if (in_valid && in_ready === 1'b1)
                exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || sat_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b expected 0", in_ready, sat_in_ready);
        end
        checks++;
        if ({out_valid, out_c32, out_prod} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b c32=%b prod=%h expected all 0",
                     out_valid, out_c32, out_prod);
        end
        checks++;
        if (ovf_cnt !== 16'd0 || sat_ovf_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_ovf_cnt: got %0d/%0d expected 0", ovf_cnt, sat_ovf_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 1", in_ready);
        end
    endtask

    // One beat into an empty pipe; checks the two-edge latency and the product.
    task automatic send_latency(input logic [31:0] s, input logic [31:0] c, input string name);
        logic [32:0] e;
        e = {1'b0, s} + {1'b0, c};
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = s;
        in_carry  = c;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got in_ready=%b expected 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: got out_valid=%b expected 0", name, out_valid);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_c32, out_prod} !== {1'b1, e}) begin
            errors++;
            $display("FAIL %s_result: got v=%b c32=%b prod=%h expected v=1 c32=%b prod=%h",
                     name, out_valid, out_c32, out_prod, e[32], e[31:0]);
        end
    endtask

    task automatic test_arith();
        send_latency(32'hFFFE_0000, 32'h0000_0001, "full_scale");
        send_latency(32'h0000_FFFF, 32'h0000_0001, "cross_half");
        send_latency(32'h7FFF_FFFF, 32'h0000_0001, "cross_top");
    endtask

    task automatic test_overflow();
        send_latency(32'h8000_0000, 32'h8000_0000, "overflow");
        @(negedge clk);
        checks++;
        if (ovf_cnt !== 16'd1 || sat_ovf_cnt !== 2'd1) begin
            errors++;
            $display("FAIL ovf_first: got %0d/%0d expected 1/1", ovf_cnt, sat_ovf_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_sum   = 32'h8000_0000;
            in_carry = 32'h8000_0000;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ovf_cnt !== 16'd5 || sat_ovf_cnt !== 2'd3) begin
            errors++;
            $display("FAIL ovf_five: got %0d/%0d expected 5/3", ovf_cnt, sat_ovf_cnt);
        end
        send_latency(32'hC000_0000, 32'h4000_0001, "overflow_hold");
        @(negedge clk);
        checks++;
        if (ovf_cnt !== 16'd6 || sat_ovf_cnt !== 2'd3) begin
            errors++;
            $display("FAIL ovf_hold: got %0d/%0d expected 6/3", ovf_cnt, sat_ovf_cnt);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 32'd1;
        in_carry  = 32'd2;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept_a: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_sum   = 32'd3;
        in_carry = 32'd4;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept_b: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_sum   = 32'd5;
        in_carry = 32'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_full_%0d: got in_ready=%b expected 0", i, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_prod !== 32'd3) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b prod=%h expected v=1 prod=3", i, out_valid, out_prod);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_prod !== 32'd3) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b prod=%h expected 1 and 3", in_ready, out_prod);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 32'd7) begin
            errors++;
            $display("FAIL bp_second: got v=%b prod=%h expected v=1 prod=7", out_valid, out_prod);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 32'd11) begin
            errors++;
            $display("FAIL bp_third: got v=%b prod=%h expected v=1 prod=b", out_valid, out_prod);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_sum   = $urandom;
            in_carry = $urandom;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready_%0d: got %b expected 1", i, in_ready);
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bubble_%0d: got out_valid=%b expected 1", i, out_valid);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b pending=%0d expected 0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 32'h0000_1234;
        in_carry  = 32'h0000_0001;
        @(posedge clk); #1;
        in_sum   = 32'hFFFF_FFFF;
        in_carry = 32'h0000_0002;
        @(posedge clk); #1;
        in_sum   = 32'h0000_0010;
        in_carry = 32'h0000_0020;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_full: got in_ready=%b v=%b expected 0/1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_c32, out_prod} !== 34'd0 || ovf_cnt !== 16'd0 || sat_ovf_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%b c32=%b prod=%h cnt=%0d/%0d expected all 0",
                     out_valid, out_c32, out_prod, ovf_cnt, sat_ovf_cnt);
        end
        send_latency(32'h0000_00FF, 32'h0000_0001, "post_reset");
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_stale: got v=%b pending=%0d expected 0/0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        test_reset();
        test_arith();
        test_overflow();
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
